rr_trace_demarshaller_n: RTL and testbench
==========================================

Name: rr_trace_demarshaller_n

Overview:
- N-way, single-stage trace demarshaller for the replay path.
- Accepts one packed replay packet per handshake. The packet carries logb_valid, loge_valid and compacted logb_data, with present channels concatenated from the LSB in channel order.
- Scatters the data to N independent valid/ready channels, with per-channel partial-completion tracking.
- Replaces cascades of 2-way splitters; sits between the replay stream FIFO and the per-interface replay channels.

Parameters:
- CHANNEL_CNT, 4, number of logb channels (N), 2..32.
- CHANNEL_W, 8, uniform slot width per channel in bits.
- LOGE_CNT, 4, number of loge_valid bits carried per packet (E).
- STAT_W, 32, width of statistics counters (optional feature only).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- in_valid  in  1  packet valid.
- in_ready  out  1  packet accepted when in_valid && in_ready.
- in_logb_valid  in  N  channels present in packet.
- in_loge_valid  in  E  loge bits of packet.
- in_data  in  N*CHANNEL_W  compacted logb data.
- out_valid  out  N  per-channel valid.
- out_ready  in  N  per-channel ready.
- out_data  out  N*CHANNEL_W  channel c data at slot [c*CHANNEL_W +: CHANNEL_W].
- out_loge_valid  out  E  loge snapshot of held packet, shared by all channels.
- e_valid  out  1  loge-only packet valid.
- e_ready  in  1  loge-only packet ready.
- stat_pkt_cnt  out  STAT_W  packets consumed (optional feature).
- stat_drop_cnt  out  STAT_W  all-zero packets dropped (optional feature).
- stat_partial_cyc  out  STAT_W  cycles spent in PARTIAL (optional feature).

Behaviour:

Holding register
- One packet register: q_valid, q_logb, q_loge, q_data, plus precomputed offsets.
- in_ready = !q_valid || q_done. The slice is pass-through capable, giving 1 packet/cycle throughput with all outputs ready.
- Latency: a packet accepted at edge T is presented on its outputs from T+1.
- Offset computation at accept: off[c] = CHANNEL_W * popcount(in_logb_valid[c-1:0]), with off[0] = 0. Width is clog2(N*CHANNEL_W+1). The offsets are registered with the packet.
- Data mapping: out_data slot c = q_data[off[c] +: CHANNEL_W] when q_logb[c]; otherwise 0.
- Bits of in_data above popcount*CHANNEL_W are ignored.

Done tracking
- Done mask D[N] tracks channels that have already handshaked for the held packet.
- out_valid[c] = q_valid && q_logb[c] && !D[c]. A channel is never re-presented once it has fired.
- A channel with out_valid low never blocks: its ready is ignored.
- out_loge_valid = q_loge while q_valid; 0 otherwise.

Packet completion
- Logb packet (q_logb != 0): q_done is high when, for every c, !q_logb[c] || D[c] || out_ready[c].
- Loge-only packet (q_logb == 0, q_loge != 0): e_valid = q_valid; q_done = e_ready.
- Empty packet (q_logb == 0, q_loge == 0): q_done = 1 with no output asserted; the packet is dropped in one cycle.
- When q_done is high: D <= 0. q_valid <= in_valid (a new packet may load in the same cycle).
- Otherwise: D[c] <= D[c] | (out_valid[c] && out_ready[c]).

States
- IDLE: q_valid = 0.
- FULL: q_valid = 1, D = 0.
- PARTIAL: q_valid = 1, D != 0.
- Transitions:
  - IDLE -> FULL on accept.
  - FULL -> IDLE or FULL on q_done, depending on whether a new packet is accepted.
  - FULL -> PARTIAL on any individual fire without q_done.
  - PARTIAL -> IDLE or FULL on q_done.

Outputs are combinational from registered state plus out_ready/e_ready; there is no combinational path from in_* to out_*.

Reset
- q_valid = 0, D = 0.
- All outputs 0, except in_ready = 1 from the first cycle after reset.
- A reset mid-PARTIAL discards the held packet; no channel is re-presented.

Optional Feature:
- Macro RR_DEMARSHAL_STATS_EN.
- When defined:
  - stat_pkt_cnt increments on each q_done with q_valid.
  - stat_drop_cnt increments on each empty-packet completion.
  - stat_partial_cyc increments on each cycle in PARTIAL.
  - All three saturate at 2^STAT_W-1 and reset to 0.
- When undefined: all stat ports are tied to 0 and no counter registers are generated.

Test Plan:
1. Scatter: N=4, W=8. Send logb=4'b1010, data=16'hBBAA, all ready=1 -> at T+1, out_valid=4'b1010, slot1=8'hAA, slot3=8'hBB, slots 0 and 2 = 0. Back-to-back packets sustain in_ready=1.
2. Partial stall: packet logb=4'b1010, out_ready=4'b1000 -> ch3 fires. Next cycle out_valid=4'b0010 and in_ready=0. Hold ch1 ready low for 3 cycles, then raise it -> single ch1 handshake, in_ready=1 in that cycle, ch3 never re-fired.
3. Loge-only: logb=0, loge=4'b0101, e_ready=0 for 2 cycles -> e_valid=1, out_valid=0, in_ready=0. On e_ready=1 the packet is consumed and out_loge_valid=4'b0101 during the hold.
4. Empty packet: logb=0, loge=0 -> consumed in 1 cycle, no valid asserted, stat_drop_cnt=1 (with RR_DEMARSHAL_STATS_EN).
5. Reset mid-operation: rstn low while in PARTIAL with D=4'b0001 -> next cycle out_valid=0, in_ready=1, D=0. A new packet is presented normally.
6. Stats: 5 packets, one of them held in PARTIAL for 4 cycles -> stat_pkt_cnt=5, stat_partial_cyc=4. With the macro undefined, all stat ports read 0.

Source files
------------

// File: rtl/rr_trace_demarshaller_n_if.sv
// rr_trace_demarshaller_n_if
//   Bundle of the replay-packet input handshake and the N per-channel output
//   handshakes of rr_trace_demarshaller_n.
//   master : the side that supplies packets and consumes channels (stream FIFO + replay channels)
//   slave  : the demarshaller itself
// Signals
//   in_valid/in_ready         packet handshake
//   in_logb_valid[N]          channels present in the packet
//   in_loge_valid[E]          loge bits of the packet
//   in_data[N*CHANNEL_W]      compacted logb data, present channels packed from the LSB
//   out_valid/out_ready[N]    per-channel handshakes
//   out_data[N*CHANNEL_W]     channel c at slot [c*CHANNEL_W +: CHANNEL_W]
//   out_loge_valid[E]         loge snapshot of the held packet
//   e_valid/e_ready           loge-only packet handshake
interface rr_trace_demarshaller_n_if #(
  parameter int CHANNEL_CNT = 4,
  parameter int CHANNEL_W   = 8,
  parameter int LOGE_CNT    = 4
);
  logic                             in_valid;
  logic                             in_ready;
  logic [CHANNEL_CNT-1:0]           in_logb_valid;
  logic [LOGE_CNT-1:0]              in_loge_valid;
  logic [CHANNEL_CNT*CHANNEL_W-1:0] in_data;
  logic [CHANNEL_CNT-1:0]           out_valid;
  logic [CHANNEL_CNT-1:0]           out_ready;
  logic [CHANNEL_CNT*CHANNEL_W-1:0] out_data;
  logic [LOGE_CNT-1:0]              out_loge_valid;
  logic                             e_valid;
  logic                             e_ready;

  modport master (
    output in_valid, in_logb_valid, in_loge_valid, in_data, out_ready, e_ready,
    input  in_ready, out_valid, out_data, out_loge_valid, e_valid
  );

  modport slave (
    input  in_valid, in_logb_valid, in_loge_valid, in_data, out_ready, e_ready,
    output in_ready, out_valid, out_data, out_loge_valid, e_valid
  );
endinterface

// File: rtl/rr_trace_demarshaller_n.sv
// rr_trace_demarshaller_n
//   Single-stage N-way trace demarshaller on the replay path. One packed replay
//   packet is held per handshake; its compacted logb data is scattered to N
//   independent valid/ready channels. A done mask remembers channels that
//   already fired so a partially consumed packet never re-presents them.
//   Loge-only packets are offered on e_valid/e_ready; empty packets are
//   dropped in one cycle.
// Ports
//   clk                 clock
//   rstn                synchronous active-low reset
//   bus (slave)         packet input and per-channel outputs, see rr_trace_demarshaller_n_if
//   stat_pkt_cnt        packets consumed                (RR_DEMARSHAL_STATS_EN)
//   stat_drop_cnt       empty packets dropped           (RR_DEMARSHAL_STATS_EN)
//   stat_partial_cyc    cycles spent in PARTIAL         (RR_DEMARSHAL_STATS_EN)
// Configuration
//   `define RR_DEMARSHAL_STATS_EN to build the saturating statistics counters;
//   otherwise the stat ports are tied to 0.
module rr_trace_demarshaller_n #(
  parameter int CHANNEL_CNT = 4,
  parameter int CHANNEL_W   = 8,
  parameter int LOGE_CNT    = 4,
  parameter int STAT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  rr_trace_demarshaller_n_if.slave bus,
  output logic [STAT_W-1:0]    stat_pkt_cnt,
  output logic [STAT_W-1:0]    stat_drop_cnt,
  output logic [STAT_W-1:0]    stat_partial_cyc
);

  localparam int DW    = CHANNEL_CNT * CHANNEL_W;
  localparam int OFF_W = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FULL    = 2'd1,
    S_PARTIAL = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CHANNEL_CNT-1:0]  r_done_p1;
  logic [CHANNEL_CNT-1:0]  w_done_nxt;

  logic [CHANNEL_CNT-1:0]  r_logb_p1;
  logic [LOGE_CNT-1:0]     r_loge_p1;
  logic [DW-1:0]           r_data_p1;
  logic [OFF_W-1:0]        r_off_p1 [CHANNEL_CNT];
  logic [OFF_W-1:0]        w_off    [CHANNEL_CNT];

  logic                    w_vld_p1;
  logic                    w_logb_any;
  logic                    w_loge_any;
  logic                    w_done_logb;
  logic                    w_q_done;
  logic                    w_accept;
  logic [CHANNEL_CNT-1:0]  w_out_valid;
  logic [CHANNEL_CNT-1:0]  w_fire;
  logic [DW-1:0]           w_out_data;

  // Slot offsets of the incoming packet: channel c starts after all present
  // lower channels. Computed once at accept so the output side only shifts.
  always_comb begin
    logic [OFF_W-1:0] v_cnt;
    v_cnt = '0;
    for (int c = 0; c < CHANNEL_CNT; c++) begin
      w_off[c] = OFF_W'(CHANNEL_W) * v_cnt;
      v_cnt    = v_cnt + OFF_W'(bus.in_logb_valid[c]);
    end
  end

  // ---- stage p1: held packet, outputs derived from registered state ----
  assign w_vld_p1    = (r_state != S_IDLE);
  assign w_logb_any  = |r_logb_p1;
  assign w_loge_any  = |r_loge_p1;
  assign w_out_valid = {CHANNEL_CNT{w_vld_p1}} & r_logb_p1 & ~r_done_p1;
  assign w_fire      = w_out_valid & bus.out_ready;

  // Every present channel is either already done or handshaking now.
  assign w_done_logb = &(~r_logb_p1 | r_done_p1 | bus.out_ready);

  always_comb begin
    w_q_done = 1'b0;
    if (w_vld_p1) begin
      if (w_logb_any)      w_q_done = w_done_logb;
      else if (w_loge_any) w_q_done = bus.e_ready;
      else                 w_q_done = 1'b1;
    end
  end

  assign w_accept = bus.in_valid && bus.in_ready;

  always_comb begin
    logic [DW-1:0] v_shift;
    w_out_data = '0;
    for (int c = 0; c < CHANNEL_CNT; c++) begin
      v_shift = r_data_p1 >> r_off_p1[c];
      if (w_vld_p1 && r_logb_p1[c])
        w_out_data[c*CHANNEL_W +: CHANNEL_W] = v_shift[CHANNEL_W-1:0];
    end
  end

  assign bus.in_ready       = !w_vld_p1 || w_q_done;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_data       = w_out_data;
  assign bus.out_loge_valid = w_vld_p1 ? r_loge_p1 : '0;
  assign bus.e_valid        = w_vld_p1 && !w_logb_any && w_loge_any;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_done_p1;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_FULL;
      end
      default: begin
        if (w_q_done) begin
          w_done_nxt  = '0;
          w_state_nxt = w_accept ? S_FULL : S_IDLE;
        end else begin
          w_done_nxt  = r_done_p1 | w_fire;
          w_state_nxt = (|w_done_nxt) ? S_PARTIAL : S_FULL;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_done_p1 <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_done_p1 <= w_done_nxt;
    end
  end

  // Packet payload is only meaningful while the state is not IDLE, and all
  // outputs are gated by that, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_logb_p1 <= bus.in_logb_valid;
      r_loge_p1 <= bus.in_loge_valid;
      r_data_p1 <= bus.in_data;
      r_off_p1  <= w_off;
    end
  end

`ifdef RR_DEMARSHAL_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [STAT_W-1:0] r_stat_pkt;
  logic [STAT_W-1:0] r_stat_drop;
  logic [STAT_W-1:0] r_stat_part;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stat_pkt  <= '0;
      r_stat_drop <= '0;
      r_stat_part <= '0;
    end else begin
      if (w_q_done)                                r_stat_pkt  <= sat_inc(r_stat_pkt);
      if (w_q_done && !w_logb_any && !w_loge_any)  r_stat_drop <= sat_inc(r_stat_drop);
      if (r_state == S_PARTIAL)                    r_stat_part <= sat_inc(r_stat_part);
    end
  end

  assign stat_pkt_cnt     = r_stat_pkt;
  assign stat_drop_cnt    = r_stat_drop;
  assign stat_partial_cyc = r_stat_part;
`else
  assign stat_pkt_cnt     = '0;
  assign stat_drop_cnt    = '0;
  assign stat_partial_cyc = '0;
`endif

endmodule

// File: tb/tb_rr_trace_demarshaller_n.sv
module tb_rr_trace_demarshaller_n;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int E  = 4;
  localparam int SW = 32;
  localparam int DW = N * W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [SW-1:0] stat_pkt_cnt, stat_drop_cnt, stat_partial_cyc;

  rr_trace_demarshaller_n_if #(.CHANNEL_CNT(N), .CHANNEL_W(W), .LOGE_CNT(E)) bus();

  rr_trace_demarshaller_n #(
    .CHANNEL_CNT(N), .CHANNEL_W(W), .LOGE_CNT(E), .STAT_W(SW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .bus              (bus),
    .stat_pkt_cnt     (stat_pkt_cnt),
    .stat_drop_cnt    (stat_drop_cnt),
    .stat_partial_cyc (stat_partial_cyc)
  );

  always #5 clk = ~clk;

  // Reference packet: per-channel expected slot contents, plus which channels
  // have been handed out so far.
  typedef struct {
    logic [N-1:0]  logb;
    logic [E-1:0]  loge;
    logic [DW-1:0] slots;
    logic [N-1:0]  fired;
  } pkt_t;

  pkt_t q[$];
  pkt_t pend;
  bit   pend_v  = 0;
  bit   mon_en  = 0;
  bit   rnd_rdy = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_pkt = 0, exp_drop = 0, exp_part = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t make_pkt(input logic [N-1:0] lb, input logic [E-1:0] le,
                                    input logic [DW-1:0] d);
    pkt_t p;
    int k;
    k = 0;
    p.logb = lb; p.loge = le; p.slots = '0; p.fired = '0;
    for (int c = 0; c < N; c++)
      if (lb[c]) begin
        p.slots[c*W +: W] = d[k*W +: W];
        k++;
      end
    return p;
  endfunction

  // Monitor: compares every output against the head packet, then applies the
  // handshakes that will commit at the coming rising edge.
  always @(negedge clk) if (mon_en) begin
    logic [N-1:0]  ev;
    logic          eev;
    logic [E-1:0]  el;
    logic          er;
    logic          done;
    logic [DW-1:0] ed;
    pkt_t          h;
    ev = '0; eev = 1'b0; el = '0; er = 1'b1; done = 1'b0; ed = '0;
    h = make_pkt('0, '0, '0);
    if (q.size() > 0) begin
      h   = q[0];
      ev  = h.logb & ~h.fired;
      eev = (h.logb == '0) && (h.loge != '0);
      el  = h.loge;
      ed  = h.slots;
      if (h.logb != '0) begin
        done = 1'b1;
        for (int c = 0; c < N; c++)
          if (h.logb[c] && !h.fired[c] && !bus.out_ready[c]) done = 1'b0;
      end else if (h.loge != '0) done = bus.e_ready;
      else done = 1'b1;
      er = done;
    end
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    chk("e_valid", 64'(bus.e_valid), 64'(eev));
    chk("out_loge_valid", 64'(bus.out_loge_valid), 64'(el));
    chk("in_ready", 64'(bus.in_ready), 64'(er));
    chk("out_data", 64'(bus.out_data), 64'(ed));
    if (!rstn) begin
      q.delete();
      exp_pkt = 0; exp_drop = 0; exp_part = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        pend   = make_pkt(bus.in_logb_valid, bus.in_loge_valid, bus.in_data);
        pend_v = 1;
      end
      if (q.size() > 0) begin
        if (h.fired != '0) exp_part++;
        h.fired = h.fired | (ev & bus.out_ready);
        if (done) begin
          void'(q.pop_front());
          exp_pkt++;
          if (h.logb == '0 && h.loge == '0) exp_drop++;
        end else q[0] = h;
      end
    end
  end

  // Accepted packet becomes the held packet at this edge.
  always @(posedge clk) if (pend_v) begin
    q.push_back(pend);
    pend_v = 0;
  end

  always @(posedge clk) if (rnd_rdy) begin
    #1;
    bus.out_ready = N'($urandom);
    bus.e_ready   = 1'($urandom);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [N-1:0] lb, input logic [E-1:0] le, input logic [DW-1:0] d);
    int t;
    t = 0;
    bus.in_valid = 1'b1; bus.in_logb_valid = lb; bus.in_loge_valid = le; bus.in_data = d;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=stalled required=accepted t=%0t", $time);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [N-1:0] lb;
    logic [E-1:0] le;
    int           t;
    bus.in_valid = 0; bus.in_logb_valid = '0; bus.in_loge_valid = '0; bus.in_data = '0;
    bus.out_ready = '0; bus.e_ready = 0;
    cyc(3);
    rstn = 1'b1;
    mon_en = 1;
    cyc(1);

    // Scatter with all ready, back-to-back.
    bus.out_ready = '1; bus.e_ready = 1;
    send(4'b1010, 4'h3, 32'hDEAD_BBAA);
    send(4'b1111, 4'h0, 32'h4433_2211);
    send(4'b0001, 4'hF, 32'h0000_00EE);
    send(4'b1100, 4'h1, 32'hFFFF_7766);
    cyc(2);

    // Partial stall: ch3 fires first, ch1 held off for 3 cycles.
    bus.out_ready = 4'b1000;
    send(4'b1010, 4'h2, 32'h0000_BBAA);
    cyc(3);
    bus.out_ready = 4'b0010;
    cyc(1);
    bus.out_ready = '1;
    cyc(1);

    // Loge-only packet held by e_ready.
    bus.e_ready = 0;
    send(4'b0000, 4'b0101, 32'h1234_5678);
    cyc(2);
    bus.e_ready = 1;
    cyc(1);

    // Empty packet.
    send(4'b0000, 4'b0000, 32'hFFFF_FFFF);
    cyc(2);

    // Reset while PARTIAL with ch0 done.
    bus.out_ready = 4'b0001;
    send(4'b0011, 4'h6, 32'h0000_5544);
    cyc(1);
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    bus.out_ready = '1;
    send(4'b0110, 4'h9, 32'h0000_CCDD);
    cyc(2);

    // Randomized traffic.
    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      t  = $urandom_range(0, 9);
      lb = (t == 0) ? '0 : N'($urandom);
      le = E'($urandom);
      if (t == 0 && $urandom_range(0, 1) == 0) le = '0;
      send(lb, le, DW'($urandom));
      if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 3));
    end
    rnd_rdy = 0;
    cyc(2);
    bus.out_ready = '1; bus.e_ready = 1;
    t = 0;
    while ((q.size() != 0 || pend_v) && t < 100) begin cyc(1); t++; end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    cyc(2);

`ifdef RR_DEMARSHAL_STATS_EN
    chk("stat_pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_pkt));
    chk("stat_drop_cnt", 64'(stat_drop_cnt), 64'(exp_drop));
    chk("stat_partial_cyc", 64'(stat_partial_cyc), 64'(exp_part));
`else
    chk("stat_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
    chk("stat_drop_cnt", 64'(stat_drop_cnt), 64'd0);
    chk("stat_partial_cyc", 64'(stat_partial_cyc), 64'd0);
`endif

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
